// File: rtl/ram_copy_pkg.sv
// ram_copy_pkg: shared types and defaults for the RAM copy engine.
//   state_t   : copy FSM states
//   DW_DEF    : default data word width
//   AW_DEF    : default address width (RAM depth 2**AW)
package ram_copy_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_copy_engine_if.sv
// ram_copy_engine_if: command and RAM-side bus of the copy engine.
//   Command : start, src_addr, dst_addr, len (in)  / busy, done (out)
//   Read    : rd_addr (out, to RAM a1), rd_q (in, from RAM q1)
//   Write   : wr_addr, wr_data, wr_en (out, to RAM a2/d2/we2)
//   checksum (out) exists only when RAM_COPY_CSUM_EN is defined.
// modport master = engine side, modport slave = requester/RAM side.
interface ram_copy_engine_if #(
    parameter int DW = 8,
    parameter int AW = 7
);
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_q;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
`ifdef RAM_COPY_CSUM_EN
    logic [DW-1:0] checksum;

    modport master (
        input  start, src_addr, dst_addr, len, rd_q,
        output busy, done, rd_addr, wr_addr, wr_data, wr_en, checksum
    );
    modport slave (
        output start, src_addr, dst_addr, len, rd_q,
        input  busy, done, rd_addr, wr_addr, wr_data, wr_en, checksum
    );
`else
    modport master (
        input  start, src_addr, dst_addr, len, rd_q,
        output busy, done, rd_addr, wr_addr, wr_data, wr_en
    );
    modport slave (
        output start, src_addr, dst_addr, len, rd_q,
        input  busy, done, rd_addr, wr_addr, wr_data, wr_en
    );
`endif
endinterface

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies len words from src to dst of a dual-port RAM with
// a 1-cycle registered read. Reads go out on port 1, writes on port 2, one
// word per cycle; the write trails its read by one cycle so the RAM output
// can be passed straight through to the write data.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ram_copy_engine_if.master (command, read port, write port)
// Optional: define RAM_COPY_CSUM_EN to add bus.checksum, the XOR of every
// word written by the current copy (cleared on start, held after done).
// Copy order is ascending; a destination that lies above the source within
// len words reads already-overwritten data and is not supported.
module ram_copy_engine
    import ram_copy_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_copy_engine_if.master bus
);

    state_t        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW:0]   count_q, count_d;     // reads still to issue
    logic          wr_en_q, wr_en_d;     // read-valid stage == write strobe
    logic          accept;
    logic [DW-1:0] rd_word;

    // start is only honoured while not busy; DONE counts as not busy
    assign accept  = bus.start && (state_q == IDLE || state_q == DONE);
    assign rd_word = bus.rd_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = (bus.len == '0) ? DONE : RUN;
                else        state_d = IDLE;
            end
            RUN:     if (count_q == (AW+1)'(1)) state_d = DRAIN;
            DRAIN:   state_d = DONE;   // one cycle for the trailing write
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        bus.busy = (state_q == RUN) || (state_q == DRAIN);
        bus.done = (state_q == DONE);
    end

    // ---------------- address / count datapath ----------------
    always_comb begin
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        // a read issued this cycle returns next cycle, where it is written
        wr_en_d   = (state_q == RUN);

        if (wr_en_q) wr_addr_d = wr_addr_q + 1'b1;

        if (accept) begin
            rd_addr_d = bus.src_addr;
            wr_addr_d = bus.dst_addr;
            count_d   = bus.len;
        end else if (state_q == RUN) begin
            rd_addr_d = rd_addr_q + 1'b1;
            count_d   = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = rd_word;

`ifdef RAM_COPY_CSUM_EN
    logic [DW-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (accept)       csum_d = '0;
        else if (wr_en_q) csum_d = csum_q ^ rd_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign bus.checksum = csum_q;
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: drives ram_copy_engine beside a behavioural dual-port
// RAM and checks cycle timing, addresses and final memory contents against
// a reference copy computed from a snapshot of the memory.
module tb_ram_copy_engine;

    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ram_copy_engine_if #(.DW(DW), .AW(AW)) bus ();

    ram_copy_engine #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // dual-port RAM, registered read on port 1, write on port 2, plus a
    // bench-only preload port
    logic [DW-1:0] mem [DEPTH];
    logic          bd_we   = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        bus.rd_q <= mem[bus.rd_addr];
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (bd_we)     mem[bd_addr]     <= bd_data;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] dd);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = dd;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // One copy: start at a negedge, then check every cycle k (k=1 is the
    // cycle after the accepting edge). glitch_k>0 pulses start with other
    // operands in that cycle; rst_k>0 asserts reset in that cycle.
    task automatic do_copy(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int n, input int glitch_k, input int rst_k,
                           output logic [DW-1:0] csum_exp);
        logic [DW-1:0] old  [DEPTH];
        logic [DW-1:0] expm [DEPTH];
        logic [AW-1:0] ea, sa;
        logic [DW-1:0] x;
        int exp_done, wcnt, nwr, bad;
        bit exp_busy, exp_wr;

        old = mem;
        nwr = n;
        // writes landing before reset in cycle rst_k: j + 2 <= rst_k - 1
        if (rst_k > 0 && rst_k - 2 < nwr) nwr = rst_k - 2;
        expm = old;
        x = '0;
        for (int j = 0; j < nwr; j++) begin
            ea = d + AW'(j);
            sa = s + AW'(j);
            expm[ea] = old[sa];
            x ^= old[sa];
        end
        csum_exp = x;
        exp_done = (n == 0) ? 1 : n + 2;

        @(negedge clk);
        bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.len = (AW+1)'(n);
        @(negedge clk);
        // operands changing after capture must have no effect
        bus.start = 1'b0;
        bus.src_addr = AW'($urandom); bus.dst_addr = AW'($urandom);
        bus.len = (AW+1)'($urandom);
        wcnt = 0;

        for (int k = 1; k <= exp_done + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                chk($sformatf("%s.rst_wr_en", tag), bus.wr_en, 0);
                chk($sformatf("%s.rst_busy", tag), bus.busy, 0);
                chk($sformatf("%s.rst_done", tag), bus.done, 0);
                chk($sformatf("%s.rst_rd_addr", tag), bus.rd_addr, 0);
                chk($sformatf("%s.rst_wr_addr", tag), bus.wr_addr, 0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            exp_busy = (n != 0) && (k <= n + 1);
            exp_wr   = (n != 0) && (k >= 2) && (k <= n + 1);
            chk($sformatf("%s.busy@%0d", tag, k), bus.busy, exp_busy);
            chk($sformatf("%s.done@%0d", tag, k), bus.done, (k == exp_done));
            chk($sformatf("%s.wr_en@%0d", tag, k), bus.wr_en, exp_wr);
            if (bus.wr_en) begin
                wcnt++;
                ea = d + AW'(k - 2);
                sa = s + AW'(k - 2);
                chk($sformatf("%s.wr_addr@%0d", tag, k), bus.wr_addr, ea);
                chk($sformatf("%s.wr_data@%0d", tag, k), bus.wr_data, old[sa]);
            end
            if (n != 0 && k <= n) begin
                sa = s + AW'(k - 1);
                chk($sformatf("%s.rd_addr@%0d", tag, k), bus.rd_addr, sa);
            end
`ifdef RAM_COPY_CSUM_EN
            if (k == 1 && n != 0) chk($sformatf("%s.csum_clr", tag), bus.checksum, 0);
            if (k == exp_done)    chk($sformatf("%s.csum_done", tag), bus.checksum, x);
`endif
            if (k == glitch_k) begin
                bus.start = 1'b1; bus.src_addr = ~s; bus.dst_addr = ~d;
                bus.len = (AW+1)'($urandom_range(1, DEPTH));
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;

        if (rst_k == 0) chk($sformatf("%s.wr_count", tag), wcnt, n);
        bad = 0;
        for (int a = 0; a < DEPTH; a++)
            if (mem[a] !== expm[a]) bad++;
        chk($sformatf("%s.mem_words_wrong", tag), bad, 0);
    endtask

    initial begin
        logic [DW-1:0] cs;
        logic [AW-1:0] s, d;
        int n;

        bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset.busy",    bus.busy,    0);
        chk("reset.done",    bus.done,    0);
        chk("reset.wr_en",   bus.wr_en,   0);
        chk("reset.rd_addr", bus.rd_addr, 0);
        chk("reset.wr_addr", bus.wr_addr, 0);
`ifdef RAM_COPY_CSUM_EN
        chk("reset.checksum", bus.checksum, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) bd_write(AW'(a), DW'($urandom));

        // basic 4-word copy
        bd_write(7'h10, 8'hA1); bd_write(7'h11, 8'hB2);
        bd_write(7'h12, 8'hC3); bd_write(7'h13, 8'hD4);
        do_copy("basic", 7'h10, 7'h40, 4, 0, 0, cs);
        chk("basic.m40", mem[7'h40], 8'hA1);
        chk("basic.m41", mem[7'h41], 8'hB2);
        chk("basic.m42", mem[7'h42], 8'hC3);
        chk("basic.m43", mem[7'h43], 8'hD4);

        // zero length: done next cycle, nothing written
        do_copy("len0", 7'h22, 7'h55, 0, 0, 0, cs);

        // both regions wrap through 0x7F -> 0x00
        do_copy("wrap", 7'h7E, 7'h7D, 4, 0, 0, cs);

        // start while busy is ignored
        do_copy("glitch", 7'h30, 7'h50, 6, 3, 0, cs);

        // reset during an 8-word copy, then a fresh copy
        do_copy("midrst", 7'h08, 7'h68, 8, 0, 3, cs);
        do_copy("postrst", 7'h18, 7'h70, 5, 0, 0, cs);

        // checksum over known data
        bd_write(7'h20, 8'h01); bd_write(7'h21, 8'h02);
        bd_write(7'h22, 8'h04); bd_write(7'h23, 8'h08);
        do_copy("csum", 7'h20, 7'h60, 4, 0, 0, cs);
`ifdef RAM_COPY_CSUM_EN
        chk("csum.held", bus.checksum, 8'h0F);
`endif

        // random non-conflicting copies (dst at least len above src, modulo)
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 40);
            s = AW'($urandom);
            d = s + AW'($urandom_range(n, DEPTH - 1));
            do_copy($sformatf("rnd%0d", t), s, d, n, 0, 0, cs);
        end

        // full-memory copy onto itself
        s = AW'($urandom);
        do_copy("full", s, s, DEPTH, 0, 0, cs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
